mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter LEN_W, default 8, burst length width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  3  burst requests: bit0 filter load (read), bit1 main-buffer load (read), bit2 OFM write.
REQ-007 addr0/addr1/addr2  input  ADDR_W each  burst base address per requester.
REQ-008 len0/len1/len2  input  LEN_W each  burst beat count per requester.
REQ-009 wdata  input  DATA_W  OFM write data for the current beat.
REQ-010 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_re.
REQ-011 mem_addr  output  ADDR_W  memory address.
REQ-012 mem_re / mem_we  output  1 each  memory read / write strobes.
REQ-013 mem_wdata  output  DATA_W  equals wdata whenever mem_we=1.
REQ-014 gnt  output  3  one-hot grant to the owning requester, zero when idle.
REQ-015 rvalid  output  3  per-requester read-data-valid; rdata output DATA_W carries mem_rdata.
REQ-016 wready  output  1  OFM writer beat accepted this cycle; writer advances wdata on the next cycle.
REQ-017 burst_done  output  3  one-cycle pulse to the requester whose burst just completed.

Function
REQ-018 FSM states: IDLE, XFER, DONE; reset state IDLE.
REQ-019 IDLE: if req!=0, select the winner round-robin, starting at index (last+1) mod 3, latch its addr/len into base/len registers, set gnt, go to XFER; else stay IDLE.
REQ-020 last resets to 2, so after reset bit0 has the highest priority.
REQ-021 last updates to the winner index in the cycle the grant is taken.
REQ-022 XFER: one beat per cycle; mem_addr = base + beat mod 2^ADDR_W; mem_re=1 for owners 0/1, mem_we=1 and wready=1 for owner 2.
REQ-023 Beat counter starts at 0, increments each XFER cycle; on beat == len-1 go to DONE.
REQ-024 len=0: no beat issued; IDLE -> XFER -> DONE in consecutive cycles with mem_re=mem_we=0 in XFER.
REQ-025 rvalid[owner] is asserted exactly one cycle after each mem_re, including the beat issued on the last XFER cycle (lands in DONE).
REQ-026 DONE: burst_done[owner]=1 for one cycle, gnt cleared, next state IDLE; no new grant in DONE.
REQ-027 Minimum inter-burst gap: one IDLE cycle between DONE and the next XFER.
REQ-028 gnt is held constant from grant through the DONE cycle's preceding edge; req deassertion mid-burst is ignored and the burst completes.
REQ-029 Address inputs and lengths are sampled only at grant; later changes do not affect the active burst.
REQ-030 mem_re and mem_we are never both 1; at most one gnt bit is 1.
REQ-031 Outputs are registered or decoded from registered state only; no combinational path from req to mem_*.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, gnt=0, mem_re=mem_we=0, mem_addr=0, rvalid=0, wready=0, burst_done=0, beat=0, last=2.
REQ-033 Reset mid-burst aborts it without burst_done; no pending rvalid is emitted after the reset edge.

Verification
REQ-034 req=3'b001, addr0=0x0010, len0=4 -> mem_re on 4 consecutive cycles, mem_addr 0x10..0x13, rvalid[0] 4 cycles lagging by 1, burst_done[0] one pulse.
REQ-035 req=3'b111 held, all len=2 -> grant order 0,1,2,0,... with one IDLE gap between bursts; gnt always one-hot.
REQ-036 req=3'b100, addr2=0xFFFF, len2=3 -> mem_we with mem_addr 0xFFFF,0x0000,0x0001, wready high 3 cycles, mem_wdata tracks wdata.
REQ-037 req=3'b010, len1=0 -> gnt[1] for XFER cycle only, no mem_re, burst_done[1] pulse next cycle.
REQ-038 rst asserted on beat 2 of a len=5 read -> next cycle all outputs zero, no burst_done, next grant is requester 0 when req=3'b111.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin burst arbiter for two read ports and one write port.
// Outputs decode from registered state only; read-data-valid is a registered copy of mem_re.
module mem_port_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   input  logic [LEN_W-1:0]  len2,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        gnt,
   output logic [2:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              wready,
   output logic [2:0]        burst_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [1:0]        owner;
   logic [1:0]        last;
   logic [1:0]        winner;
   logic [1:0]        cand0;
   logic [1:0]        cand1;
   logic [1:0]        cand2;
   logic [ADDR_W-1:0] base;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  beat;
   logic [2:0]        rvalid_r;
   logic [2:0]        owner_oh;
   logic              last_beat;
   logic              beat_en;
   logic              take_grant;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Search order starts one past the previous winner, wrapping modulo 3.
   always_comb begin
      cand0  = next_idx(last);
      cand1  = next_idx(cand0);
      cand2  = next_idx(cand1);
      winner = cand2;
      if (req[cand0]) begin
         winner = cand0;
      end else if (req[cand1]) begin
         winner = cand1;
      end
   end

   assign take_grant = (state == IDLE) && (req != 3'b000);
   assign last_beat  = (len_r == '0) || (beat == len_r - LEN_W'(1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req != 3'b000) state_nx = XFER;
         XFER:    if (last_beat) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= 2'd0;
         last     <= 2'd2;
         base     <= '0;
         len_r    <= '0;
         beat     <= '0;
         rvalid_r <= 3'b000;
      end else begin
         state    <= state_nx;
         rvalid_r <= mem_re ? owner_oh : 3'b000;
         if (take_grant) begin
            owner <= winner;
            last  <= winner;
            beat  <= '0;
            case (winner)
               2'd0:    begin base <= addr0; len_r <= len0; end
               2'd1:    begin base <= addr1; len_r <= len1; end
               default: begin base <= addr2; len_r <= len2; end
            endcase
         end else if (state == XFER && !last_beat) begin
            beat <= beat + LEN_W'(1);
         end
      end
   end

   // A zero-length burst still passes through XFER but issues no beat.
   assign owner_oh   = 3'b001 << owner;
   assign beat_en    = (state == XFER) && (len_r != '0);
   assign gnt        = (state == XFER) ? owner_oh : 3'b000;
   assign mem_re     = beat_en && (owner != 2'd2);
   assign mem_we     = beat_en && (owner == 2'd2);
   assign wready     = mem_we;
   assign mem_addr   = beat_en ? base + ADDR_W'(beat) : '0;
   assign mem_wdata  = wdata;
   assign rvalid     = rvalid_r;
   assign rdata      = mem_rdata;
   assign burst_done = (state == DONE) ? owner_oh : 3'b000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = 3'b000;
   logic [15:0] addr0 = '0, addr1 = '0, addr2 = '0;
   logic [7:0]  len0 = '0, len1 = '0, len2 = '0;
   logic [7:0]  wdata = '0;
   logic [7:0]  mem_rdata = '0;
   logic [15:0] mem_addr;
   logic        mem_re, mem_we, wready;
   logic [7:0]  mem_wdata, rdata;
   logic [2:0]  gnt, rvalid, burst_done;

   int checks = 0;
   int failures = 0;

   logic [15:0] exp_addr[$];
   logic [7:0]  exp_data[$];
   int          exp_own[$];

   mem_port_arbiter dut (
      .clk(clk), .rst(rst), .req(req),
      .addr0(addr0), .addr1(addr1), .addr2(addr2),
      .len0(len0), .len1(len1), .len2(len2),
      .wdata(wdata), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .wready(wready), .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   // Memory model: read data is a fixed function of the address, one cycle later.
   always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

   function automatic logic [15:0] base_of(input int o);
      return (o == 0) ? 16'h0100 : (o == 1) ? 16'h0200 : 16'h0300;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req = 3'b000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
      checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_strobes got re=%b we=%b exp=0/0", mem_re, mem_we); end
      checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", mem_addr); end
      checks++; if (rvalid !== 3'b000 || wready !== 1'b0 || burst_done !== 3'b000) begin failures++; $display("FAIL reset_flags got rvalid=%b wready=%b done=%b exp=0", rvalid, wready, burst_done); end
      rst = 1'b0;
   endtask

   task automatic test_read_burst();
      int n_re = 0, n_rv = 0, n_done = 0, first_re = -1, last_re = -1;
      logic prev_re = 1'b0;
      logic [15:0] a;
      logic [7:0]  d;
      exp_addr.delete(); exp_data.delete();
      addr0 = 16'h0010; len0 = 8'd4; req = 3'b001;
      for (int i = 0; i < 4; i++) exp_addr.push_back(16'h0010 + 16'(i));
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (gnt != 3'b000) req = 3'b000;
         if (rvalid != 3'b000) begin
            checks++;
            if (rvalid !== 3'b001 || !prev_re || exp_data.size() == 0) begin
               failures++; $display("FAIL read_rvalid got=%b prev_re=%b exp=001 after mem_re", rvalid, prev_re);
            end else begin
               d = exp_data.pop_front();
               if (rdata !== d) begin failures++; $display("FAIL read_rdata got=%h exp=%h", rdata, d); end
            end
            n_rv++;
         end
         if (mem_re) begin
            checks++;
            if (exp_addr.size() == 0) begin
               failures++; $display("FAIL read_extra_beat got addr=%h exp=none", mem_addr);
            end else begin
               a = exp_addr.pop_front();
               if (mem_addr !== a || gnt !== 3'b001) begin failures++; $display("FAIL read_addr got=%h gnt=%b exp=%h gnt=001", mem_addr, gnt, a); end
               exp_data.push_back(a[7:0] ^ 8'h5A);
            end
            if (first_re < 0) first_re = cyc;
            last_re = cyc;
            n_re++;
         end
         if (burst_done != 3'b000) begin
            checks++; if (burst_done !== 3'b001) begin failures++; $display("FAIL read_done_vec got=%b exp=001", burst_done); end
            n_done++;
         end
         prev_re = mem_re;
      end
      checks++; if (n_re != 4 || last_re - first_re != 3) begin failures++; $display("FAIL read_beats got=%0d span=%0d exp=4 span=3", n_re, last_re - first_re); end
      checks++; if (n_rv != 4) begin failures++; $display("FAIL read_rvalid_count got=%0d exp=4", n_rv); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL read_done_count got=%0d exp=1", n_done); end
   endtask

   task automatic test_round_robin();
      int grants = 0, since_done = -1, o;
      logic [2:0]  prev_gnt = 3'b000;
      logic [15:0] a;
      do_reset();
      exp_addr.delete(); exp_own.delete();
      addr0 = base_of(0); addr1 = base_of(1); addr2 = base_of(2);
      len0 = 8'd2; len1 = 8'd2; len2 = 8'd2;
      for (int i = 0; i < 6; i++) exp_own.push_back(i % 3);
      req = 3'b111;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         checks++; if (!(gnt == 3'b000 || $onehot(gnt)) || (mem_re && mem_we)) begin failures++; $display("FAIL rr_onehot got gnt=%b re=%b we=%b exp=onehot,exclusive", gnt, mem_re, mem_we); end
         if (gnt != 3'b000 && prev_gnt == 3'b000) begin
            checks++;
            if (exp_own.size() == 0) begin
               failures++; $display("FAIL rr_extra_grant got=%b exp=none", gnt);
               o = 0;
            end else begin
               o = exp_own.pop_front();
               if (gnt !== (3'b001 << o)) begin failures++; $display("FAIL rr_order got=%b exp=%b", gnt, 3'b001 << o); end
            end
            if (grants > 0) begin
               checks++; if (since_done != 1) begin failures++; $display("FAIL rr_gap got=%0d exp=1 idle cycle", since_done); end
            end
            grants++;
            exp_addr.push_back(base_of(o));
            exp_addr.push_back(base_of(o) + 16'd1);
            if (grants == 6) req = 3'b000;
         end
         if (mem_re || mem_we) begin
            checks++;
            if (exp_addr.size() == 0) begin
               failures++; $display("FAIL rr_extra_beat got addr=%h exp=none", mem_addr);
            end else begin
               a = exp_addr.pop_front();
               if (mem_addr !== a || mem_we !== (gnt == 3'b100)) begin failures++; $display("FAIL rr_beat got addr=%h we=%b exp addr=%h we=%b", mem_addr, mem_we, a, gnt == 3'b100); end
            end
         end
         if (burst_done != 3'b000) since_done = 0;
         else if (since_done >= 0) since_done++;
         prev_gnt = gnt;
      end
      checks++; if (grants != 6 || exp_addr.size() != 0) begin failures++; $display("FAIL rr_total got grants=%0d left=%0d exp=6/0", grants, exp_addr.size()); end
   endtask

   task automatic test_write_wrap();
      int n_we = 0, n_done = 0;
      logic [15:0] a;
      logic [7:0]  d;
      exp_addr.delete(); exp_data.delete();
      exp_addr.push_back(16'hFFFF); exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001);
      exp_data.push_back(8'h11); exp_data.push_back(8'h22); exp_data.push_back(8'h33);
      wdata = 8'h11; addr2 = 16'hFFFF; len2 = 8'd3; req = 3'b100;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (gnt != 3'b000) req = 3'b000;
         if (mem_re || (wready !== mem_we)) begin failures++; checks++; $display("FAIL wr_strobes got re=%b we=%b wready=%b exp re=0 wready=we", mem_re, mem_we, wready); end
         if (mem_we) begin
            checks++;
            if (exp_addr.size() == 0) begin
               failures++; $display("FAIL wr_extra_beat got addr=%h exp=none", mem_addr);
            end else begin
               a = exp_addr.pop_front(); d = exp_data.pop_front();
               if (mem_addr !== a || mem_wdata !== d || gnt !== 3'b100) begin failures++; $display("FAIL wr_beat got addr=%h data=%h gnt=%b exp addr=%h data=%h gnt=100", mem_addr, mem_wdata, gnt, a, d); end
            end
            n_we++;
            wdata = wdata + 8'h11;
         end
         if (burst_done != 3'b000) begin
            checks++; if (burst_done !== 3'b100) begin failures++; $display("FAIL wr_done_vec got=%b exp=100", burst_done); end
            n_done++;
         end
      end
      checks++; if (n_we != 3 || n_done != 1) begin failures++; $display("FAIL wr_counts got beats=%0d done=%0d exp=3/1", n_we, n_done); end
   endtask

   task automatic test_zero_len();
      int g_n = 0, g_cyc = -1, d_n = 0, d_cyc = -1, beats = 0;
      len1 = 8'd0; req = 3'b010;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (gnt != 3'b000) req = 3'b000;
         if (gnt == 3'b010) begin g_n++; g_cyc = cyc; end
         if (mem_re || mem_we || rvalid != 3'b000) beats++;
         if (burst_done == 3'b010) begin d_n++; d_cyc = cyc; end
      end
      checks++; if (g_n != 1) begin failures++; $display("FAIL zl_gnt_cycles got=%0d exp=1", g_n); end
      checks++; if (beats != 0) begin failures++; $display("FAIL zl_beats got=%0d exp=0", beats); end
      checks++; if (d_n != 1 || d_cyc != g_cyc + 1) begin failures++; $display("FAIL zl_done got n=%0d at=%0d exp n=1 at=%0d", d_n, d_cyc, g_cyc + 1); end
   endtask

   task automatic test_reset_mid_burst();
      int n_re = 0, bad = 0;
      logic hit = 1'b0;
      addr0 = 16'h0040; len0 = 8'd5; req = 3'b001;
      for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
         @(negedge clk);
         if (mem_re) begin
            n_re++;
            if (n_re == 3) begin
               checks++; if (mem_addr !== 16'h0042) begin failures++; $display("FAIL rm_beat2_addr got=%h exp=0042", mem_addr); end
               rst = 1'b1; req = 3'b000; hit = 1'b1;
            end
         end
      end
      checks++; if (!hit) begin failures++; $display("FAIL rm_timeout got beats=%0d exp=3", n_re); end
      @(negedge clk);
      rst = 1'b0;
      checks++; if (gnt !== 3'b000 || mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin failures++; $display("FAIL rm_zero got gnt=%b re=%b we=%b addr=%h exp=0", gnt, mem_re, mem_we, mem_addr); end
      checks++; if (rvalid !== 3'b000 || wready !== 1'b0 || burst_done !== 3'b000) begin failures++; $display("FAIL rm_flags got rvalid=%b wready=%b done=%b exp=0", rvalid, wready, burst_done); end
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         if (burst_done != 3'b000 || rvalid != 3'b000) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL rm_late_events got=%0d exp=0", bad); end
      len0 = 8'd1; len1 = 8'd1; len2 = 8'd1; req = 3'b111;
      hit = 1'b0;
      for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
         @(negedge clk);
         if (gnt != 3'b000) begin
            hit = 1'b1; req = 3'b000;
            checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL rm_next_grant got=%b exp=001", gnt); end
         end
      end
      if (!hit) begin checks++; failures++; $display("FAIL rm_grant_timeout got=none exp=001"); end
      repeat (6) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_read_burst();
      test_round_robin();
      test_write_wrap();
      test_zero_len();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
